// File: rtl/ibus_arb_if.sv
//------------------------------------------------------------------------------
// Module      : ibus_arb_if
// Description : CPU/DMA request ports and BSC-side bus of the arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface ibus_arb_if;
  logic [31:0] C_A;
  logic [31:0] D_A;
  logic [31:0] C_DI;
  logic [31:0] D_DI;
  logic [3:0]  C_BA;
  logic [3:0]  D_BA;
  logic        C_WE;
  logic        D_WE;
  logic        C_REQ;
  logic        D_REQ;
  logic        C_LOCK;
  logic        D_LOCK;
  logic        C_BUSY;
  logic        D_BUSY;
  logic [31:0] C_DO;
  logic [31:0] D_DO;
  logic [31:0] S_A;
  logic [31:0] S_DI;
  logic [3:0]  S_BA;
  logic        S_WE;
  logic        S_REQ;
  logic        S_LOCK;
  logic [31:0] S_DO;
  logic        S_BUSY;
  logic [1:0]  OWNER;

  // Arbiter view: serves the two requesters, drives the BSC.
  modport slave (
    input  C_A, D_A, C_DI, D_DI, C_BA, D_BA, C_WE, D_WE,
    input  C_REQ, D_REQ, C_LOCK, D_LOCK,
    output C_BUSY, D_BUSY, C_DO, D_DO,
    output S_A, S_DI, S_BA, S_WE, S_REQ, S_LOCK, OWNER,
    input  S_DO, S_BUSY
  );

  // Environment view: requesters and BSC around the arbiter.
  modport master (
    output C_A, D_A, C_DI, D_DI, C_BA, D_BA, C_WE, D_WE,
    output C_REQ, D_REQ, C_LOCK, D_LOCK,
    input  C_BUSY, D_BUSY, C_DO, D_DO,
    input  S_A, S_DI, S_BA, S_WE, S_REQ, S_LOCK, OWNER,
    output S_DO, S_BUSY
  );
endinterface

`default_nettype wire

// File: rtl/ibus_arb.sv
//------------------------------------------------------------------------------
// Module      : ibus_arb
// Description : CPU/DMA bus arbiter with bus lock and DMA starvation limit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module ibus_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE_R,
  ibus_arb_if.slave  bus
);

  localparam logic [1:0] c_idle      = 2'b00;
  localparam logic [1:0] c_own_c     = 2'b01;
  localparam logic [1:0] c_own_d     = 2'b10;
  localparam logic [2:0] c_starve_max = 3'(STARVE_MAX);
  localparam logic [2:0] c_sc_sat     = 3'd7;

  logic [1:0] r_state;
  logic [2:0] r_sc;

  logic w_sel_d;
  logic w_sel_c;
  logic w_route_c;
  logic w_route_d;
  logic w_s_req;

  // DMA keeps priority until it has starved a waiting CPU STARVE_MAX times.
  always_comb begin
    w_sel_d   = bus.D_REQ && ((r_sc < c_starve_max) || !bus.C_REQ);
    w_sel_c   = bus.C_REQ && !w_sel_d;
    w_route_c = (r_state == c_own_c) || ((r_state == c_idle) && w_sel_c);
    w_route_d = (r_state == c_own_d) || ((r_state == c_idle) && w_sel_d);
  end

  always_comb begin
    bus.S_A    = 32'd0;
    bus.S_DI   = 32'd0;
    bus.S_BA   = 4'd0;
    bus.S_WE   = 1'b0;
    bus.S_LOCK = 1'b0;
    w_s_req    = 1'b0;
    if (w_route_c) begin
      bus.S_A    = bus.C_A;
      bus.S_DI   = bus.C_DI;
      bus.S_BA   = bus.C_BA;
      bus.S_WE   = bus.C_WE;
      bus.S_LOCK = bus.C_LOCK;
      w_s_req    = bus.C_REQ;
    end else if (w_route_d) begin
      bus.S_A    = bus.D_A;
      bus.S_DI   = bus.D_DI;
      bus.S_BA   = bus.D_BA;
      bus.S_WE   = bus.D_WE;
      bus.S_LOCK = bus.D_LOCK;
      w_s_req    = bus.D_REQ;
    end
  end

  // Reset masks the combinational request/busy paths as well as the state.
  assign bus.S_REQ  = w_s_req && !RST;
  assign bus.C_BUSY = !RST && ((r_state == c_own_c) ? bus.S_BUSY : bus.C_REQ);
  assign bus.D_BUSY = !RST && ((r_state == c_own_d) ? bus.S_BUSY : bus.D_REQ);
  assign bus.C_DO   = bus.S_DO;
  assign bus.D_DO   = bus.S_DO;
  assign bus.OWNER  = r_state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_idle;
      r_sc    <= 3'd0;
    end else if (CE_R) begin
      case (r_state)
        c_idle: begin
          if (w_s_req && !bus.S_BUSY) begin
            if (w_sel_d) begin
              r_state <= c_own_d;
              if (bus.C_REQ)
                r_sc <= (r_sc == c_sc_sat) ? c_sc_sat : r_sc + 3'd1;
              else
                r_sc <= 3'd0;
            end else begin
              r_state <= c_own_c;
              r_sc    <= 3'd0;
            end
          end
        end
        c_own_c: begin
          if (!bus.S_BUSY && !bus.C_LOCK)
            r_state <= c_idle;
        end
        c_own_d: begin
          if (!bus.S_BUSY && !bus.D_LOCK)
            r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ibus_arb.sv
//------------------------------------------------------------------------------
// Module      : tb_ibus_arb
// Description : Directed self-checking bench for ibus_arb.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ibus_arb;

  logic CLK = 1'b0;
  logic RST;
  logic CE_R;

  ibus_arb_if bus();

  ibus_arb #(.STARVE_MAX(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .CE_R (CE_R),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] c_ca = 32'h1000_00C0;
  logic [31:0] c_da = 32'h2000_0D00;
  logic [31:0] c_cdi = 32'hC0DE_0001;
  logic [31:0] c_sdo = 32'hCAFE_F00D;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;  CE_R = 1'b1;
    bus.C_A = 32'd0; bus.D_A = 32'd0; bus.C_DI = 32'd0; bus.D_DI = 32'd0;
    bus.C_BA = 4'd0; bus.D_BA = 4'd0; bus.C_WE = 1'b0; bus.D_WE = 1'b0;
    bus.C_LOCK = 1'b0; bus.D_LOCK = 1'b0; bus.S_BUSY = 1'b0; bus.S_DO = 32'd0;
    bus.C_REQ = 1'b1; bus.D_REQ = 1'b1;
    #2;
    // reset masks requests
    check("rst_owner", 32'(bus.OWNER), 32'd0);
    check("rst_sreq", 32'(bus.S_REQ), 32'd0);
    check("rst_cbusy", 32'(bus.C_BUSY), 32'd0);
    check("rst_dbusy", 32'(bus.D_BUSY), 32'd0);
    step;
    bus.C_REQ = 1'b0; bus.D_REQ = 1'b0; bus.S_DO = c_sdo;
    RST = 1'b0;
    #1;
    check("idle_sreq", 32'(bus.S_REQ), 32'd0);
    check("idle_sa_zero", bus.S_A, 32'd0);
    check("idle_sba_zero", 32'(bus.S_BA), 32'd0);
    check("c_do", bus.C_DO, c_sdo);
    check("d_do", bus.D_DO, c_sdo);

    // single CPU access with BSC busy for two enables
    bus.C_A = c_ca; bus.C_DI = c_cdi; bus.C_BA = 4'h3; bus.C_WE = 1'b1; bus.C_REQ = 1'b1;
    #1;
    check("c_win_sa", bus.S_A, c_ca);
    check("c_win_sdi", bus.S_DI, c_cdi);
    check("c_win_sba", 32'(bus.S_BA), 32'h3);
    check("c_win_swe", 32'(bus.S_WE), 32'd1);
    check("c_win_sreq", 32'(bus.S_REQ), 32'd1);
    check("c_win_cbusy", 32'(bus.C_BUSY), 32'd1);
    check("c_win_owner", 32'(bus.OWNER), 32'd0);
    step;
    check("c_own_owner", 32'(bus.OWNER), 32'd1);
    bus.S_BUSY = 1'b1;
    #1;
    check("c_own_busy_hi", 32'(bus.C_BUSY), 32'd1);
    step; step;
    check("c_own_hold", 32'(bus.OWNER), 32'd1);
    bus.S_BUSY = 1'b0;
    #1;
    check("c_own_busy_lo", 32'(bus.C_BUSY), 32'd0);
    bus.C_REQ = 1'b0;
    step;
    check("c_done_owner", 32'(bus.OWNER), 32'd0);
    check("c_done_swe", 32'(bus.S_WE), 32'd0);

    // DMA priority until the starvation limit, then one CPU grant
    bus.D_A = c_da; bus.D_REQ = 1'b1; bus.C_REQ = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      check("d_win_sa", bus.S_A, c_da);
      check("d_win_cbusy", 32'(bus.C_BUSY), 32'd1);
      step;
      check("d_own_owner", 32'(bus.OWNER), 32'd2);
      check("d_own_cbusy", 32'(bus.C_BUSY), 32'd1);
      check("d_own_dbusy", 32'(bus.D_BUSY), 32'd0);
      step;
      check("d_done_owner", 32'(bus.OWNER), 32'd0);
    end
    check("starve_c_win_sa", bus.S_A, c_ca);
    check("starve_dbusy", 32'(bus.D_BUSY), 32'd1);
    step;
    check("starve_c_owner", 32'(bus.OWNER), 32'd1);
    check("starve_c_dbusy", 32'(bus.D_BUSY), 32'd1);
    step;
    check("d_resume_sa", bus.S_A, c_da);
    bus.C_REQ = 1'b0; bus.D_REQ = 1'b0;
    step;
    check("no_req_owner", 32'(bus.OWNER), 32'd0);

    // DMA lock holds the bus across three accesses
    bus.D_LOCK = 1'b1; bus.D_REQ = 1'b1; bus.C_REQ = 1'b1;
    step;
    for (int k = 0; k < 3; k++) begin
      check("lock_owner", 32'(bus.OWNER), 32'd2);
      check("lock_cbusy", 32'(bus.C_BUSY), 32'd1);
      check("lock_slock", 32'(bus.S_LOCK), 32'd1);
      step;
    end
    bus.D_LOCK = 1'b0; bus.D_REQ = 1'b0;
    #1;
    check("unlock_owner", 32'(bus.OWNER), 32'd2);
    step;
    check("unlock_idle", 32'(bus.OWNER), 32'd0);
    check("unlock_c_win", bus.S_A, c_ca);
    step;
    check("unlock_c_owner", 32'(bus.OWNER), 32'd1);

    // reset mid-ownership while the BSC is busy
    bus.S_BUSY = 1'b1; bus.C_LOCK = 1'b1;
    step;
    check("pre_rst_owner", 32'(bus.OWNER), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_owner", 32'(bus.OWNER), 32'd0);
    check("mid_rst_sreq", 32'(bus.S_REQ), 32'd0);
    check("mid_rst_cbusy", 32'(bus.C_BUSY), 32'd0);
    step;
    check("mid_rst_hold", 32'(bus.OWNER), 32'd0);
    RST = 1'b0; bus.S_BUSY = 1'b0; bus.C_LOCK = 1'b0;
    #1;
    check("post_rst_sreq", 32'(bus.S_REQ), 32'd1);
    check("post_rst_sa", bus.S_A, c_ca);
    step;
    check("post_rst_owner", 32'(bus.OWNER), 32'd1);
    bus.C_REQ = 1'b0;
    step;
    check("post_rst_idle", 32'(bus.OWNER), 32'd0);

    // no state change without CE_R, even as the winner flips
    CE_R = 1'b0; bus.C_REQ = 1'b1; bus.D_REQ = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("ce_low_owner", 32'(bus.OWNER), 32'd0);
      bus.D_REQ = (i != 2);
      step;
    end
    CE_R = 1'b1;
    #1;
    check("ce_resume_sa", bus.S_A, c_da);
    step;
    check("ce_resume_owner", 32'(bus.OWNER), 32'd2);
    CE_R = 1'b0;
    step;
    check("ce_low_own_hold", 32'(bus.OWNER), 32'd2);
    CE_R = 1'b1; bus.D_REQ = 1'b0;
    step;
    check("ce_d_done", 32'(bus.OWNER), 32'd0);
    step;
    check("ce_c_owner", 32'(bus.OWNER), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
